// File: rtl/fwd_pkg.sv
// Shared types and helpers for the forwarding / interlock unit.
// Register fields are packed 5 bits per port or per stage.
package fwd_pkg;

    localparam int REG_W = 5;
    localparam int REG_VEC_W = 32 * REG_W;

    typedef logic [REG_W-1:0] reg_idx_t;
    typedef logic [4:0] stg_idx_t;

    localparam reg_idx_t REG_X0 = '0;

    // Extract field idx from a packed register-index vector.
    function automatic reg_idx_t reg_at(
        input logic [REG_VEC_W-1:0] vec,
        input stg_idx_t idx
    );
        return vec[idx*REG_W +: REG_W];
    endfunction

endpackage

// File: rtl/fwd_scoreboard.sv
// Busy bits for long-latency destinations; x0 is never busy.
// A set on the same register as a clear wins, two clears coexist.
module fwd_scoreboard
    import fwd_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        set_en,
    input  reg_idx_t    set_rd,
    input  logic        lw_en,
    input  reg_idx_t    lw_rd,
    input  logic        fl_en,
    input  reg_idx_t    fl_rd,
    output logic [31:0] busy
);

    logic [31:0] busy_q;
    logic [31:0] busy_nxt;

    // Apply clears first so a coincident set overrides them.
    always_comb begin
        busy_nxt = busy_q;
        if (lw_en) busy_nxt[lw_rd] = 1'b0;
        if (fl_en) busy_nxt[fl_rd] = 1'b0;
        if (set_en) busy_nxt[set_rd] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    // Scoreboard state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy_q <= '0;
        else        busy_q <= busy_nxt;
    end

    assign busy = busy_q;

endmodule

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding and interlock for NRD ports over NSTG stages.
// Youngest matching stage wins; not-ready match or busy reg stalls.
module fwd_hazard_unit
    import fwd_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int NRD  = 2,
    parameter int NSTG = 3,
    parameter int TMO  = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NRD*5-1:0]     rs,
    input  logic [NRD-1:0]       rs_used,
    input  logic [NSTG-1:0]      st_valid,
    input  logic [NSTG*5-1:0]    st_rd,
    input  logic [NSTG-1:0]      st_rdy,
    input  logic [NSTG*XLEN-1:0] st_dat,
    input  logic                 iss_valid,
    input  logic                 iss_long,
    input  logic [4:0]           iss_rd,
    input  logic                 lw_valid,
    input  logic [4:0]           lw_rd,
    input  logic                 flush,
    input  logic                 ex_long,
    output logic [NRD-1:0]       fwd_en,
    output logic [NRD*XLEN-1:0]  fwd_dat,
    output logic                 stall,
    output logic                 iss_ready,
    output logic [31:0]          stall_cnt,
    output logic                 timeout
);

    localparam int RUN_W = $clog2(TMO + 1);

    logic [31:0]      busy;
    logic [NRD-1:0]   stall_p;
    logic [RUN_W-1:0] run;
    logic             sb_set;

    for (genvar p = 0; p < NRD; p++) begin : g_port
        reg_idx_t        rs_p;
        logic            act;
        logic            hit;
        logic            hit_rdy;
        logic [XLEN-1:0] hit_dat;

        assign rs_p = reg_at(REG_VEC_W'(rs), stg_idx_t'(p));
        assign act  = rs_used[p] && (rs_p != REG_X0);

        // Scan oldest to youngest so the youngest match is kept.
        always_comb begin
            hit     = 1'b0;
            hit_rdy = 1'b0;
            hit_dat = '0;
            for (int s = NSTG - 1; s >= 0; s--) begin
                if (st_valid[s] &&
                    reg_at(REG_VEC_W'(st_rd), stg_idx_t'(s)) == rs_p) begin
                    hit     = 1'b1;
                    hit_rdy = st_rdy[s];
                    hit_dat = st_dat[s*XLEN +: XLEN];
                end
            end
        end

        assign fwd_en[p] = act & hit & hit_rdy;
        assign fwd_dat[p*XLEN +: XLEN] =
            (act & hit & hit_rdy) ? hit_dat : '0;
        assign stall_p[p] = act & (hit ? ~hit_rdy : busy[rs_p]);
    end

    assign stall     = |stall_p;
    assign iss_ready = ~stall;
    assign sb_set    = iss_valid & iss_ready & iss_long &
                       (iss_rd != REG_X0);

    fwd_scoreboard u_sb (
        .clk    (clk),
        .rst_n  (rst_n),
        .set_en (sb_set),
        .set_rd (iss_rd),
        .lw_en  (lw_valid),
        .lw_rd  (lw_rd),
        .fl_en  (flush & ex_long),
        .fl_rd  (reg_at(REG_VEC_W'(st_rd), stg_idx_t'(0))),
        .busy   (busy)
    );

    // Saturating count of all stall cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cnt <= '0;
        else if (stall && stall_cnt != 32'hFFFF_FFFF)
            stall_cnt <= stall_cnt + 32'd1;
    end

    // Consecutive-stall run length and sticky timeout on the TMO-th edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run     <= '0;
            timeout <= 1'b0;
        end else if (stall) begin
            if (run != RUN_W'(TMO)) run <= run + RUN_W'(1);
            if (run == RUN_W'(TMO - 1)) timeout <= 1'b1;
        end else begin
            run <= '0;
        end
    end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench: stimulus pushes expectations, a monitor
// pops and compares them on the falling edge of each cycle.
module tb_fwd_hazard_unit;

    localparam int XLEN = 32;
    localparam int NRD  = 2;
    localparam int NSTG = 3;
    localparam int TMO  = 4;

    localparam int K_EN  = 0;
    localparam int K_D0  = 1;
    localparam int K_D1  = 2;
    localparam int K_STL = 3;
    localparam int K_RDY = 4;
    localparam int K_CNT = 5;
    localparam int K_TMO = 6;

    typedef struct {
        string       name;
        int          kind;
        logic [31:0] val;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NRD*5-1:0]     rs;
    logic [NRD-1:0]       rs_used;
    logic [NSTG-1:0]      st_valid;
    logic [NSTG*5-1:0]    st_rd;
    logic [NSTG-1:0]      st_rdy;
    logic [NSTG*XLEN-1:0] st_dat;
    logic                 iss_valid;
    logic                 iss_long;
    logic [4:0]           iss_rd;
    logic                 lw_valid;
    logic [4:0]           lw_rd;
    logic                 flush;
    logic                 ex_long;
    logic [NRD-1:0]       fwd_en;
    logic [NRD*XLEN-1:0]  fwd_dat;
    logic                 stall;
    logic                 iss_ready;
    logic [31:0]          stall_cnt;
    logic                 timeout;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    fwd_hazard_unit #(
        .XLEN(XLEN), .NRD(NRD), .NSTG(NSTG), .TMO(TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .rs(rs), .rs_used(rs_used),
        .st_valid(st_valid), .st_rd(st_rd), .st_rdy(st_rdy),
        .st_dat(st_dat), .iss_valid(iss_valid), .iss_long(iss_long),
        .iss_rd(iss_rd), .lw_valid(lw_valid), .lw_rd(lw_rd),
        .flush(flush), .ex_long(ex_long), .fwd_en(fwd_en),
        .fwd_dat(fwd_dat), .stall(stall), .iss_ready(iss_ready),
        .stall_cnt(stall_cnt), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic ex(input string n, input int k, input logic [31:0] v);
        exp_t e;
        e.name = n;
        e.kind = k;
        e.val  = v;
        q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rs = '0; rs_used = '0; st_valid = '0; st_rd = '0;
        st_rdy = '0; st_dat = '0; iss_valid = 0; iss_long = 0;
        iss_rd = '0; lw_valid = 0; lw_rd = '0; flush = 0; ex_long = 0;
    endtask

    // Monitor: compare every pending expectation mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            while (q.size() > 0) begin
                exp_t e;
                logic [31:0] act;
                e = q.pop_front();
                case (e.kind)
                    K_EN:    act = 32'(fwd_en);
                    K_D0:    act = fwd_dat[31:0];
                    K_D1:    act = fwd_dat[63:32];
                    K_STL:   act = 32'(stall);
                    K_RDY:   act = 32'(iss_ready);
                    K_CNT:   act = stall_cnt;
                    default: act = 32'(timeout);
                endcase
                checks++;
                if (act !== e.val) begin
                    errors++;
                    $display("FAIL %s: got %h want %h", e.name, act, e.val);
                end
            end
        end
    end

    initial begin
        idle();
        rst_n = 1'b0;
        #1;
        ex("rst_cnt", K_CNT, 0);
        ex("rst_tmo", K_TMO, 0);
        ex("rst_stall", K_STL, 0);
        ex("rst_rdy", K_RDY, 1);
        step();
        step();
        rst_n = 1'b1;

        // Youngest of two matching stages forwards.
        step();
        rs[4:0] = 5; rs_used = 2'b01;
        st_valid = 3'b101; st_rdy = 3'b101;
        st_rd[4:0] = 5; st_rd[14:10] = 5;
        st_dat[31:0] = 32'hAAAA; st_dat[95:64] = 32'h1111;
        ex("young_en", K_EN, 1);
        ex("young_dat", K_D0, 32'hAAAA);
        ex("young_stall", K_STL, 0);

        // Load in EX not ready: stall, no fallback to stage1.
        step();
        idle();
        rs[9:5] = 7; rs_used = 2'b10;
        st_valid = 3'b011; st_rd[4:0] = 7; st_rd[9:5] = 7;
        st_rdy = 3'b010; st_dat[63:32] = 32'h2222;
        ex("ld_stall", K_STL, 1);
        ex("ld_rdy", K_RDY, 0);
        ex("ld_en", K_EN, 0);
        step();
        st_valid = 3'b010; st_rd[4:0] = 0;
        ex("st1_en", K_EN, 2);
        ex("st1_dat", K_D1, 32'h2222);
        ex("st1_stall", K_STL, 0);
        ex("cnt1", K_CNT, 1);

        // Long write to x9, retire clears it.
        step();
        idle();
        iss_valid = 1; iss_long = 1; iss_rd = 9;
        ex("iss9_stall", K_STL, 0);
        step();
        idle();
        rs[4:0] = 9; rs_used = 2'b01;
        lw_valid = 1; lw_rd = 9;
        ex("busy9_stall", K_STL, 1);
        ex("busy9_en", K_EN, 0);
        step();
        lw_valid = 0;
        ex("ret9_stall", K_STL, 0);
        ex("cnt2", K_CNT, 2);

        // Set and retire on x9 together: set wins.
        step();
        idle();
        iss_valid = 1; iss_long = 1; iss_rd = 9;
        lw_valid = 1; lw_rd = 9;
        step();
        idle();
        rs[4:0] = 9; rs_used = 2'b01;
        lw_valid = 1; lw_rd = 9;
        ex("coll_stall", K_STL, 1);
        step();
        lw_valid = 0;
        ex("coll_clr", K_STL, 0);
        ex("cnt3", K_CNT, 3);

        // x0 never forwards or stalls, never becomes busy.
        step();
        idle();
        rs_used = 2'b01; st_valid = 3'b111;
        iss_valid = 1; iss_long = 1;
        ex("x0_en", K_EN, 0);
        ex("x0_stall", K_STL, 0);
        step();
        idle();
        rs_used = 2'b11;
        ex("x0_busy", K_STL, 0);

        // Flush of x3 and retire of x4 in the same cycle.
        step();
        idle();
        iss_valid = 1; iss_long = 1; iss_rd = 3;
        step();
        iss_rd = 4;
        step();
        idle();
        flush = 1; ex_long = 1; st_rd[4:0] = 3;
        lw_valid = 1; lw_rd = 4;
        step();
        idle();
        rs[4:0] = 3; rs[9:5] = 4; rs_used = 2'b11;
        ex("flush_stall", K_STL, 0);
        ex("cnt_flush", K_CNT, 3);

        // Six-cycle interlock on x12 with TMO=4.
        step();
        idle();
        iss_valid = 1; iss_long = 1; iss_rd = 12;
        for (int k = 1; k <= 6; k++) begin
            step();
            idle();
            rs[4:0] = 12; rs_used = 2'b01;
            if (k == 6) begin
                lw_valid = 1; lw_rd = 12;
            end
            ex($sformatf("run_stall%0d", k), K_STL, 1);
            ex($sformatf("run_cnt%0d", k), K_CNT, 32'(3 + k - 1));
            ex($sformatf("run_tmo%0d", k), K_TMO, (k >= 5) ? 1 : 0);
        end
        step();
        idle();
        rs[4:0] = 12; rs_used = 2'b01;
        ex("post_stall", K_STL, 0);
        ex("post_cnt", K_CNT, 9);
        ex("post_tmo", K_TMO, 1);
        step();
        ex("hold_tmo", K_TMO, 1);

        // Reset in the middle of a stall clears all state.
        step();
        idle();
        iss_valid = 1; iss_long = 1; iss_rd = 13;
        step();
        idle();
        rs[4:0] = 6; rs_used = 2'b01;
        st_valid = 3'b001; st_rd[4:0] = 6;
        step();
        step();
        rst_n = 1'b0;
        ex("mrst_cnt", K_CNT, 0);
        ex("mrst_tmo", K_TMO, 0);
        ex("mrst_stall", K_STL, 1);
        step();
        rst_n = 1'b1;
        idle();
        rs[4:0] = 13; rs_used = 2'b01;
        ex("mrst_busy", K_STL, 0);
        ex("mrst_cnt2", K_CNT, 0);
        step();
        ex("mrst_cnt3", K_CNT, 0);
        ex("mrst_tmo3", K_TMO, 0);

        step();
        step();
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
